// File: rtl/alu_self_test.sv
// Purpose: board self-test sequencer; drives NUM_VEC pseudo-random vectors to an external ALU and scores them against a golden model.
// Latency: at most one vector per tick; each result is sampled SETTLE+1 clocks after its operands are registered.
// Backpressure: none; start presses outside IDLE/DONE are dropped. Macro ALU_SELF_TEST_ERR_CAPTURE_EN adds first-failure capture.
module alu_self_test #(
    parameter int          WIDTH   = 8,
    parameter int          DIV     = 100_000_000,
    parameter int          NUM_VEC = 16,
    parameter int          SETTLE  = 2,
    parameter logic [15:0] SEED    = 16'hACE1,
    localparam int         CW      = $clog2(NUM_VEC + 1),
    localparam int         IW      = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1
) (
    input  logic             CLK_100MHZ,
    input  logic             BTN0,
    input  logic             BTN1,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    output logic             alu_cin,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_cout,
    output logic [CW-1:0]    pass_cnt,
    output logic [CW-1:0]    fail_cnt,
    output logic             busy,
    output logic             done,
    output logic [3:0]       LED,
    output logic [IW-1:0]    err_idx,
    output logic [WIDTH:0]   err_exp,
    output logic [WIDTH:0]   err_got
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_CHECK, S_DONE} state_t;

    localparam int             TW          = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int             SW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [TW-1:0]  TICK_LAST   = TW'(DIV - 1);
    localparam logic [IW-1:0]  IDX_LAST    = IW'(NUM_VEC - 1);
    localparam logic [SW-1:0]  SETTLE_INIT = SW'(SETTLE - 1);
    localparam logic [WIDTH:0] ONE         = {{WIDTH{1'b0}}, 1'b1};

    state_t           state_q;
    logic [TW-1:0]    tick_cnt_q;
    logic             tick;
    logic             hb_q;
    logic             btn_meta_q, btn_sync_q, btn_prev_q;
    logic             start_pls, start_acc;
    logic [15:0]      lfsr_q, lfsr_s1, lfsr_s2;
    logic [2:0]       vec_op_q;
    logic [IW-1:0]    idx_q;
    logic [SW-1:0]    settle_q;
    logic [WIDTH-1:0] a_q, b_q, a_d, b_d;
    logic [2:0]       op_q;
    logic             cin_q;
    logic [WIDTH:0]   exp_q, exp_d, got;
    logic             chk_fail;
    logic [CW-1:0]    pass_q, fail_q;
    logic             busy_q, done_q;

    // One Galois step of the x^16+x^14+x^13+x^11+1 LFSR, shifting right.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    assign tick      = (tick_cnt_q == TICK_LAST);
    assign start_pls = btn_sync_q & ~btn_prev_q;
    assign start_acc = start_pls && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign lfsr_s1   = lfsr_step(lfsr_q);
    assign lfsr_s2   = lfsr_step(lfsr_s1);
    assign a_d       = lfsr_s1[WIDTH-1:0];
    assign b_d       = lfsr_s2[WIDTH-1:0];
    assign got       = {alu_cout, alu_y};
    assign chk_fail  = (state_q == S_CHECK) && (got != exp_q);

    // Golden result for the vector about to be loaded; logic ops never carry.
    always_comb begin
        exp_d = '0;
        case (vec_op_q)
            3'd0:    exp_d = {1'b0, a_d} + {1'b0, b_d};
            3'd1:    exp_d = {1'b0, a_d} + {1'b0, ~b_d} + ONE;
            3'd2:    exp_d = {1'b0, a_d & b_d};
            3'd3:    exp_d = {1'b0, a_d | b_d};
            3'd4:    exp_d = {1'b0, a_d ^ b_d};
            default: exp_d = '0;
        endcase
    end

    // Free-running tick divider and heartbeat, independent of the FSM.
    always_ff @(posedge CLK_100MHZ or posedge BTN0) begin
        if (BTN0) begin
            tick_cnt_q <= '0;
            hb_q       <= 1'b0;
        end else begin
            tick_cnt_q <= tick ? '0 : tick_cnt_q + TW'(1);
            if (tick) hb_q <= ~hb_q;
        end
    end

    // Two-flop synchroniser for the start button plus a delay flop for edge detection.
    always_ff @(posedge CLK_100MHZ or posedge BTN0) begin
        if (BTN0) begin
            btn_meta_q <= 1'b0;
            btn_sync_q <= 1'b0;
            btn_prev_q <= 1'b0;
        end else begin
            btn_meta_q <= BTN1;
            btn_sync_q <= btn_meta_q;
            btn_prev_q <= btn_sync_q;
        end
    end

    // Run sequencer: load on tick, let the ALU settle, score, repeat NUM_VEC times.
    always_ff @(posedge CLK_100MHZ or posedge BTN0) begin
        if (BTN0) begin
            state_q  <= S_IDLE;
            lfsr_q   <= SEED;
            vec_op_q <= '0;
            idx_q    <= '0;
            settle_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            cin_q    <= 1'b0;
            exp_q    <= '0;
            pass_q   <= '0;
            fail_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_acc) begin
                        state_q  <= S_LOAD;
                        lfsr_q   <= SEED;
                        vec_op_q <= '0;
                        idx_q    <= '0;
                        pass_q   <= '0;
                        fail_q   <= '0;
                        busy_q   <= 1'b1;
                        done_q   <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (tick) begin
                        a_q      <= a_d;
                        b_q      <= b_d;
                        op_q     <= vec_op_q;
                        cin_q    <= (vec_op_q == 3'd1);
                        exp_q    <= exp_d;
                        lfsr_q   <= lfsr_s2;
                        settle_q <= SETTLE_INIT;
                        state_q  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (settle_q == '0) state_q <= S_CHECK;
                    else                settle_q <= settle_q - SW'(1);
                end
                S_CHECK: begin
                    if (chk_fail) fail_q <= fail_q + CW'(1);
                    else          pass_q <= pass_q + CW'(1);
                    if (idx_q == IDX_LAST) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        idx_q    <= idx_q + IW'(1);
                        vec_op_q <= (vec_op_q == 3'd4) ? 3'd0 : vec_op_q + 3'd1;
                        state_q  <= S_LOAD;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign alu_a    = a_q;
    assign alu_b    = b_q;
    assign alu_op   = op_q;
    assign alu_cin  = cin_q;
    assign pass_cnt = pass_q;
    assign fail_cnt = fail_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign LED      = {(fail_q != '0), done_q & (fail_q == '0), busy_q, hb_q};

`ifdef ALU_SELF_TEST_ERR_CAPTURE_EN
    logic             err_vld_q;
    logic [IW-1:0]    err_idx_q;
    logic [WIDTH:0]   err_exp_q, err_got_q;

    // Hold the first failing vector of a run; later failures are ignored.
    always_ff @(posedge CLK_100MHZ or posedge BTN0) begin
        if (BTN0) begin
            err_vld_q <= 1'b0;
            err_idx_q <= '0;
            err_exp_q <= '0;
            err_got_q <= '0;
        end else if (start_acc) begin
            err_vld_q <= 1'b0;
            err_idx_q <= '0;
            err_exp_q <= '0;
            err_got_q <= '0;
        end else if (chk_fail && !err_vld_q) begin
            err_vld_q <= 1'b1;
            err_idx_q <= idx_q;
            err_exp_q <= exp_q;
            err_got_q <= got;
        end
    end

    assign err_idx = err_idx_q;
    assign err_exp = err_exp_q;
    assign err_got = err_got_q;
`else
    assign err_idx = '0;
    assign err_exp = '0;
    assign err_got = '0;
`endif

endmodule

// File: tb/tb_alu_self_test.sv
// Bench for alu_self_test: two instances (8-bit/16 vectors and 4-bit/5 vectors) looped back to behavioural ALUs.
// Expected vectors come from an arithmetic model of the LFSR and op rotation.
// A fault switch corrupts AND results on the 8-bit loopback.
module tb_alu_self_test;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic btn0, btn1, bad_and;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] a1, b1, y1;
    logic [2:0] op1;
    logic       cin1, cout1, busy1, done1;
    logic [4:0] pass1, fail1;
    logic [3:0] led1, eidx1;
    logic [8:0] eexp1, egot1;

    logic [3:0] a2, b2, y2;
    logic [2:0] op2;
    logic       cin2, cout2, busy2, done2;
    logic [2:0] pass2, fail2, eidx2;
    logic [3:0] led2;
    logic [4:0] eexp2, egot2;

    alu_self_test #(.WIDTH(8), .DIV(4), .NUM_VEC(16), .SETTLE(2), .SEED(16'hACE1)) dut (
        .CLK_100MHZ(clk), .BTN0(btn0), .BTN1(btn1),
        .alu_a(a1), .alu_b(b1), .alu_op(op1), .alu_cin(cin1), .alu_y(y1), .alu_cout(cout1),
        .pass_cnt(pass1), .fail_cnt(fail1), .busy(busy1), .done(done1), .LED(led1),
        .err_idx(eidx1), .err_exp(eexp1), .err_got(egot1));

    alu_self_test #(.WIDTH(4), .DIV(4), .NUM_VEC(5), .SETTLE(2), .SEED(16'hACE1)) dut4 (
        .CLK_100MHZ(clk), .BTN0(btn0), .BTN1(btn1),
        .alu_a(a2), .alu_b(b2), .alu_op(op2), .alu_cin(cin2), .alu_y(y2), .alu_cout(cout2),
        .pass_cnt(pass2), .fail_cnt(fail2), .busy(busy2), .done(done2), .LED(led2),
        .err_idx(eidx2), .err_exp(eexp2), .err_got(egot2));

    // Behavioural 8-bit ALU, optionally corrupting bit 0 of AND results.
    always_comb begin
        {cout1, y1} = 9'h000;
        case (op1)
            3'd0: {cout1, y1} = {1'b0, a1} + {1'b0, b1} + {8'h00, cin1};
            3'd1: {cout1, y1} = {1'b0, a1} + {1'b0, ~b1} + {8'h00, cin1};
            3'd2: y1 = a1 & b1;
            3'd3: y1 = a1 | b1;
            3'd4: y1 = a1 ^ b1;
            default: {cout1, y1} = 9'h000;
        endcase
        if (bad_and && op1 == 3'd2) y1[0] = ~y1[0];
    end

    // Behavioural 4-bit ALU.
    always_comb begin
        {cout2, y2} = 5'h00;
        case (op2)
            3'd0: {cout2, y2} = {1'b0, a2} + {1'b0, b2} + {4'h0, cin2};
            3'd1: {cout2, y2} = {1'b0, a2} + {1'b0, ~b2} + {4'h0, cin2};
            3'd2: y2 = a2 & b2;
            3'd3: y2 = a2 | b2;
            3'd4: y2 = a2 ^ b2;
            default: {cout2, y2} = 5'h00;
        endcase
    end

    // Reference model: vector i uses two LFSR steps and op i mod 5.
    int m_a[16], m_b[16], m_op[16], m_exp[16];

    function automatic int lfsr_next(int v);
        return (v & 1) ? ((v >> 1) ^ 'hB400) : (v >> 1);
    endfunction

    task automatic build_model();
        int l;
        l = 'hACE1;
        for (int i = 0; i < 16; i++) begin
            l = lfsr_next(l);  m_a[i] = l & 255;
            l = lfsr_next(l);  m_b[i] = l & 255;
            m_op[i] = i % 5;
            case (m_op[i])
                0: m_exp[i] = m_a[i] + m_b[i];
                1: m_exp[i] = m_a[i] - m_b[i] + 256;
                2: m_exp[i] = m_a[i] & m_b[i];
                3: m_exp[i] = m_a[i] | m_b[i];
                default: m_exp[i] = m_a[i] ^ m_b[i];
            endcase
        end
    endtask

    // Record the driven vector whenever the 8-bit instance scores one, plus how often it moved meanwhile.
    typedef struct packed {logic [7:0] a; logic [7:0] b; logic [2:0] op; logic cin;} vec_t;
    vec_t obs_q[$];
    int   obs_chg[$];
    vec_t prev_v;
    int   prev_cnt = 0;
    int   chg = 0;
    always @(negedge clk) begin
        vec_t cur;
        int   cnt;
        cur = {a1, b1, op1, cin1};
        cnt = int'(pass1) + int'(fail1);
        if (cur !== prev_v) chg = chg + 1;
        if (btn0) chg = 0;
        else if (cnt == prev_cnt + 1) begin
            obs_q.push_back(cur);
            obs_chg.push_back(chg);
            chg = 0;
        end else if (cnt != prev_cnt) chg = 0;
        prev_v   = cur;
        prev_cnt = cnt;
    end

    task automatic pulse_start();
        repeat ($urandom_range(0, 3)) @(negedge clk);
        @(negedge clk);
        btn1 = 1'b1;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        btn1 = 1'b0;
    endtask

    // Wait for a fresh run of the 8-bit instance to finish; reports timeout and idle gaps.
    task automatic wait_done1(output bit to, output int gaps);
        bit seen;
        to = 1'b1; gaps = 0; seen = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (busy1) seen = 1'b1;
            else if (seen) begin
                if (done1) begin to = 1'b0; break; end
                gaps++;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        btn0 = 1'b1; btn1 = 1'b0; bad_and = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if ({a1, b1, op1, cin1} !== 20'h0) begin errors++; $display("FAIL reset_alu1 got %h want 0", {a1, b1, op1, cin1}); end
        checks++; if ({pass1, fail1, busy1, done1, led1} !== 16'h0) begin errors++; $display("FAIL reset_stat1 got %h want 0", {pass1, fail1, busy1, done1, led1}); end
        checks++; if ({eidx1, eexp1, egot1} !== 22'h0) begin errors++; $display("FAIL reset_err1 got %h want 0", {eidx1, eexp1, egot1}); end
        checks++; if ({a2, b2, op2, cin2, pass2, fail2, busy2, done2, led2} !== 24'h0) begin errors++; $display("FAIL reset_all4 got %h want 0", {a2, b2, op2, cin2, pass2, fail2, busy2, done2, led2}); end
        repeat ($urandom_range(1, 5)) @(negedge clk);
        btn0 = 1'b0;
        repeat (12) @(negedge clk);
        checks++; if (busy1 !== 1'b0 || done1 !== 1'b0) begin errors++; $display("FAIL idle_no_start busy=%b done=%b want 0 0", busy1, done1); end
    endtask

    task automatic test_correct_run();
        bit to; int gaps, first;
        first = obs_q.size();
        pulse_start();
        wait_done1(to, gaps);
        checks++; if (to) begin errors++; $display("FAIL run_timeout done=%b want 1", done1); end
        checks++; if (gaps != 0) begin errors++; $display("FAIL run_busy_gap gaps=%0d want 0", gaps); end
        checks++; if (pass1 !== 5'd16 || fail1 !== 5'd0) begin errors++; $display("FAIL run_counts pass=%0d fail=%0d want 16 0", pass1, fail1); end
        checks++; if (led1[3:1] !== 3'b010) begin errors++; $display("FAIL run_leds got %b want 010", led1[3:1]); end
        checks++; if (obs_q.size() - first != 16) begin errors++; $display("FAIL run_nvec got %0d want 16", obs_q.size() - first); end
        checks++;
        if (obs_q.size() <= first || obs_q[first].op !== 3'd0 || obs_q[first].cin !== 1'b0 ||
            obs_q[first].a !== 8'(m_a[0]) || obs_q[first].b !== 8'(m_b[0])) begin
            errors++; $display("FAIL vec0 got %h want a=%h b=%h op=0 cin=0", (obs_q.size() > first) ? obs_q[first] : '0, m_a[0], m_b[0]);
        end
        for (int i = 0; i < 16 && first + i < obs_q.size(); i++) begin
            vec_t e;
            e = {8'(m_a[i]), 8'(m_b[i]), 3'(m_op[i]), (m_op[i] == 1)};
            checks++; if (obs_q[first + i] !== e || obs_chg[first + i] > 1) begin
                errors++; $display("FAIL run_vec%0d got %h (moves %0d) want %h (moves<=1)", i, obs_q[first + i], obs_chg[first + i], e);
            end
        end
    endtask

    task automatic test_bad_and();
        bit to; int gaps, nfail, fi;
        nfail = 0; fi = -1;
        for (int i = 0; i < 16; i++) if (m_op[i] == 2) begin nfail++; if (fi < 0) fi = i; end
        bad_and = 1'b1;
        pulse_start();
        wait_done1(to, gaps);
        checks++; if (to) begin errors++; $display("FAIL bad_timeout done=%b want 1", done1); end
        checks++; if (pass1 !== 5'(16 - nfail) || fail1 !== 5'(nfail)) begin errors++; $display("FAIL bad_counts pass=%0d fail=%0d want %0d %0d", pass1, fail1, 16 - nfail, nfail); end
        checks++; if (led1[3:2] !== 2'b10) begin errors++; $display("FAIL bad_leds got %b want 10", led1[3:2]); end
`ifdef ALU_SELF_TEST_ERR_CAPTURE_EN
        checks++; if (eidx1 !== 4'(fi)) begin errors++; $display("FAIL err_idx got %0d want %0d", eidx1, fi); end
        checks++; if (eexp1 !== 9'(m_exp[fi])) begin errors++; $display("FAIL err_exp got %h want %h", eexp1, 9'(m_exp[fi])); end
        checks++; if (egot1 !== (9'(m_exp[fi]) ^ 9'h001)) begin errors++; $display("FAIL err_got got %h want %h", egot1, 9'(m_exp[fi]) ^ 9'h001); end
`else
        checks++; if ({eidx1, eexp1, egot1} !== 22'h0) begin errors++; $display("FAIL err_tied got %h want 0", {eidx1, eexp1, egot1}); end
`endif
        bad_and = 1'b0;
    endtask

    task automatic test_midrun_start();
        bit to, hit; int gaps, first;
        first = obs_q.size();
        pulse_start();
        hit = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (int'(pass1) + int'(fail1) == 5 && busy1) begin hit = 1'b1; break; end
        end
        checks++; if (!hit) begin errors++; $display("FAIL mid_reach5 count=%0d want 5", pass1 + fail1); end
        btn1 = 1'b1; repeat (2) @(negedge clk); btn1 = 1'b0;
        wait_done1(to, gaps);
        checks++; if (to || pass1 !== 5'd16 || obs_q.size() - first != 16) begin
            errors++; $display("FAIL mid_ignored pass=%0d nvec=%0d to=%b want 16 16 0", pass1, obs_q.size() - first, to);
        end
        // Restart from DONE; counters must clear when the run is accepted.
        first = obs_q.size();
        repeat ($urandom_range(0, 3)) @(negedge clk);
        btn1 = 1'b1; hit = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (!done1) begin hit = 1'b1; break; end
        end
        btn1 = 1'b0;
        checks++; if (!hit || pass1 !== 5'd0 || fail1 !== 5'd0 || busy1 !== 1'b1) begin
            errors++; $display("FAIL restart_clear pass=%0d fail=%0d busy=%b done=%b want 0 0 1 0", pass1, fail1, busy1, done1);
        end
        wait_done1(to, gaps);
        checks++; if (to || pass1 !== 5'd16 || obs_q.size() - first != 16) begin
            errors++; $display("FAIL restart_run pass=%0d nvec=%0d want 16 16", pass1, obs_q.size() - first);
        end
        for (int i = 0; i < 16 && first + i < obs_q.size(); i++) begin
            vec_t e;
            e = {8'(m_a[i]), 8'(m_b[i]), 3'(m_op[i]), (m_op[i] == 1)};
            checks++; if (obs_q[first + i] !== e) begin errors++; $display("FAIL restart_vec%0d got %h want %h", i, obs_q[first + i], e); end
        end
    endtask

    task automatic test_reset_midrun();
        bit to, hit; int gaps;
        vec_t v;
        pulse_start();
        hit = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (int'(pass1) + int'(fail1) == 9 && busy1) begin hit = 1'b1; break; end
        end
        v = {a1, b1, op1, cin1};
        for (int c = 0; c < 10 && hit; c++) begin
            @(negedge clk);
            if ({a1, b1, op1, cin1} !== v) break;
        end
        checks++; if (!hit || {a1, b1} !== {8'(m_a[9]), 8'(m_b[9])}) begin errors++; $display("FAIL rst_reach9 got %h want %h", {a1, b1}, {8'(m_a[9]), 8'(m_b[9])}); end
        btn0 = 1'b1;
        #1;
        checks++; if ({a1, b1, op1, cin1, pass1, fail1, busy1, done1, led1, eidx1, eexp1, egot1} !== 58'h0) begin
            errors++; $display("FAIL rst_mid got %h want 0", {a1, b1, op1, cin1, pass1, fail1, busy1, done1, led1, eidx1, eexp1, egot1});
        end
        repeat ($urandom_range(2, 4)) @(negedge clk);
        btn0 = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (busy1 !== 1'b0 || pass1 !== 5'd0) begin errors++; $display("FAIL rst_idle busy=%b pass=%0d want 0 0", busy1, pass1); end
        pulse_start();
        wait_done1(to, gaps);
        checks++; if (to || pass1 !== 5'd16 || fail1 !== 5'd0) begin errors++; $display("FAIL rst_rerun pass=%0d fail=%0d want 16 0", pass1, fail1); end
    endtask

    task automatic test_width4();
        bit seen, fin; int last, nt;
        bit hb;
        pulse_start();
        seen = 1'b0; fin = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (busy2) seen = 1'b1;
            else if (seen && done2) begin fin = 1'b1; break; end
        end
        checks++; if (!fin) begin errors++; $display("FAIL w4_timeout done=%b want 1", done2); end
        checks++; if (pass2 !== 3'd5 || fail2 !== 3'd0) begin errors++; $display("FAIL w4_counts pass=%0d fail=%0d want 5 0", pass2, fail2); end
        checks++; if (led2[3:2] !== 2'b01) begin errors++; $display("FAIL w4_leds got %b want 01", led2[3:2]); end
        hb = led2[0]; last = -1; nt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (led2[0] !== hb) begin
                if (last >= 0) begin
                    checks++; if (c - last != 4) begin errors++; $display("FAIL w4_heartbeat period %0d want 4", c - last); end
                end
                last = c; nt++; hb = led2[0];
            end
        end
        checks++; if (nt < 9) begin errors++; $display("FAIL w4_toggles got %0d want >=9", nt); end
    endtask

    initial begin
        build_model();
        test_reset();
        test_correct_run();
        test_bad_and();
        test_midrun_start();
        test_reset_midrun();
        test_width4();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_self_test.md
Name: alu_self_test

Overview:
- Board-level self-test sequencer for the parametrised ALU.
- Replaces a fixed demo that only ever added three hard-coded operand pairs.
- Generates NUM_VEC pseudo-random vectors across five ops, drives them to an external ALU instance, and checks each result against an internal golden model.
- Reports pass/fail counts and status on LEDs; everything runs in one clock domain with a tick enable, with no derived clocks.

Parameters:
- WIDTH, 8: ALU operand width; legal range 4..16.
- DIV, 100_000_000: clocks per tick (vector pacing); must be ≥ 2.
- NUM_VEC, 16: vectors per run; must be ≥ 1.
- SETTLE, 2: clocks between driving a vector and checking it; must be ≥ 1.
- SEED, 16'hACE1: LFSR seed; must be nonzero.

Ports:
- CLK_100MHZ  in  1  system clock.
- BTN0  in  1  asynchronous, active-high reset.
- BTN1  in  1  start button, asynchronous; synchronised internally.
- alu_a  out  WIDTH  operand A to the ALU.
- alu_b  out  WIDTH  operand B to the ALU.
- alu_op  out  3  op select to the ALU.
- alu_cin  out  1  carry-in to the ALU.
- alu_y  in  WIDTH  ALU result.
- alu_cout  in  1  ALU carry-out.
- pass_cnt  out  $clog2(NUM_VEC+1)  number of passing vectors.
- fail_cnt  out  $clog2(NUM_VEC+1)  number of failing vectors.
- busy  out  1  run in progress.
- done  out  1  run complete.
- LED  out  4  status LEDs.
- err_idx  out  $clog2(NUM_VEC)  index of first failing vector (optional feature).
- err_exp  out  WIDTH+1  expected {cout,y} of first failure (optional feature).
- err_got  out  WIDTH+1  observed {cout,y} of first failure (optional feature).

Behaviour:
- Reset (BTN0=1, async): all outputs 0; FSM=IDLE; tick counter 0; LFSR=SEED; synchroniser flops 0.
- Tick: counter runs 0..DIV-1 and wraps. tick is a 1-cycle pulse when counter==DIV-1. Free-running in every state.
- Start: BTN1 passes a 2-flop synchroniser, then a rising-edge detect (start_pls). start_pls is honoured only in IDLE and DONE; ignored otherwise.
- Op encoding (fixed): 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR. Op for vector i = i mod 5.
- Golden model, all mod 2^WIDTH:
  - ADD: {cout,y} = A+B.
  - SUB: {cout,y} = A+~B+1.
  - AND/OR/XOR: y = bitwise result, expected cout = 0.
- alu_cin: 1 for SUB, 0 otherwise.
- LFSR: 16-bit Galois, mask 16'hB400, right-shift; advances exactly twice per vector. A = low WIDTH bits after the 1st step; B = low WIDTH bits after the 2nd step.
- FSM:
  - IDLE: on start_pls → LOAD; clear idx, pass_cnt, fail_cnt, done and error regs; LFSR=SEED.
  - LOAD: wait for tick; on tick register alu_a, alu_b, alu_op, alu_cin and the expected value; settle counter = SETTLE-1; → WAIT.
  - WAIT: decrement the settle counter; at 0 → CHECK. alu_* outputs stay stable from LOAD through CHECK.
  - CHECK (1 cycle): compare {alu_cout,alu_y} against expected; increment pass_cnt or fail_cnt. If idx==NUM_VEC-1 → DONE, else idx+1 and → LOAD.
  - DONE: done=1; counters held; start_pls → same actions as IDLE start.
- Outputs: busy=1 in LOAD/WAIT/CHECK. done is cleared on entering LOAD.
- Throughput: at most one vector per tick. Run length ≤ NUM_VEC ticks plus SETTLE+1 clocks.
- LED mapping:
  - LED[0] toggles on each tick (heartbeat).
  - LED[1] = busy.
  - LED[2] = done & (fail_cnt==0).
  - LED[3] = (fail_cnt!=0).
- Reset asserted mid-run: immediate return to reset values; any partial run is discarded.
- Counters cannot overflow: they are sized for NUM_VEC.

Optional Feature:
- Macro: ALU_SELF_TEST_ERR_CAPTURE_EN.
- Defined: on the first CHECK failure of a run, latch err_idx, err_exp and err_got; later failures leave them unchanged. They are cleared on start and reset.
- Undefined: err_idx, err_exp and err_got are tied to 0 and no capture registers exist.

Test Plan:
- Bench setup for all scenarios: WIDTH=8, DIV=4, SETTLE=2, NUM_VEC=16, behavioural correct ALU on the loopback.
- Correct ALU, pulse BTN1 → busy for the run, then done=1, pass_cnt=16, fail_cnt=0, LED[2]=1, LED[3]=0.
- ALU inverts y[0] for AND only → idx 2, 7 and 12 fail: pass_cnt=13, fail_cnt=3, LED[3]=1; with the macro defined, err_idx=2 and err_got = err_exp ^ 9'h001.
- Vector 0 check → alu_op=000, alu_cin=0, operands equal to SEED stepped once and twice (low 8 bits); alu_* stable from LOAD through CHECK.
- Pulse BTN1 mid-run at idx 5 → ignored, run completes with 16 vectors. Pulse again in DONE → counters clear and the run restarts with identical vectors.
- Assert BTN0 during WAIT of idx 9 → all outputs 0, FSM IDLE; the next start produces pass_cnt=16.
- WIDTH=4, NUM_VEC=5 with correct ALU → SUB wrap cases (A<B) match, pass_cnt=5; LED[0] toggles every 4 clocks.
